// File: rtl/line_backing_memory.sv
// Line-granular backing store behind the data cache: whole-line fills and
// write-backs with a fixed programmable access latency, one request in flight.
module line_backing_memory #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 256,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    mem_ready,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    is_write_done
);

  localparam int LINE_W         = BLOCK_SIZE * 8;
  localparam int WORDS_PER_LINE = BLOCK_SIZE / 4;
  localparam int OFS_BITS       = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS       = $clog2(NUM_LINES);
  localparam int CNT_W          = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [LINE_W-1:0]   dout_q, dout_d;
  logic                ov_q, ov_d;
  logic                wd_q, wd_d;
  logic                mem_we;
  logic                accept;

  // Array contents survive reset; only power-up clears them.
  logic [LINE_W-1:0] mem_q [NUM_LINES] = '{default: '0};

  // Offset and high address bits are deliberately ignored (lines wrap).
  logic [31:0] unused_addr_bits;
  assign unused_addr_bits = addr & ~(32'(NUM_LINES - 1) << OFS_BITS);

  assign accept = is_input_valid && (mem_read ^ mem_write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    data_d  = data_q;
    dout_d  = dout_q;
    ov_d    = 1'b0;
    wd_d    = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = addr[OFS_BITS+IDX_BITS-1:OFS_BITS];
          wr_d    = mem_write;
          data_d  = din;
          cnt_d   = CNT_W'(DELAY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          if (wr_q) begin
            mem_we = 1'b1;
            wd_d   = 1'b1;
          end else begin
            dout_d = mem_q[idx_q];
            ov_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
      wd_q    <= wd_d;
    end
  end

  // mem_we is only raised in BUSY, so an asynchronous reset aborts a pending write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign mem_ready       = (state_q == IDLE);
  assign is_output_valid = ov_q;
  assign is_write_done   = wd_q;
  assign dout            = dout_q;

endmodule
